// File: rtl/ysyx_23060201_mem_arb_if.sv
// Bundle of requester (IFU, LSU) and memory-side signals around the pmem arbiter.
// Handshake rule for every *_valid/*_ready pair: a transfer happens on the rising
// edge where both are 1; the sender holds valid and payload stable until then,
// and the receiver never drops ready within a cycle.
interface ysyx_23060201_mem_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_raddr;
  logic                  ifu_resp_valid;
  logic                  ifu_resp_ready;
  logic [DATA_WIDTH-1:0] ifu_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic                  lsu_wen;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic [7:0]            lsu_wmask;
  logic                  lsu_resp_valid;
  logic                  lsu_resp_ready;
  logic [DATA_WIDTH-1:0] lsu_rdata;

  logic                  mem_ren;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [7:0]            mem_wmask;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  ifu_req_valid, ifu_raddr, ifu_resp_ready,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  // Requester/memory environment view.
  modport master (
    output ifu_req_valid, ifu_raddr, ifu_resp_ready,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_23060201_mem_arb.sv
// Two-requester (IFU/LSU) round-robin arbiter and sequencer for the single pmem
// port: one transaction in flight, one strobe per transaction, fixed latency
// MEM_LAT from strobe to response, response held until the owner accepts it.
module ysyx_23060201_mem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_23060201_mem_arb_if.slave  bus,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t                state_q;
  logic                  prio_lsu_q;   // 1: LSU wins a contested grant
  logic                  owner_lsu_q;
  logic                  wen_q;
  logic                  strobe_q;     // high only in the first ACCESS cycle
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            wmask_q;
  logic [DATA_WIDTH-1:0] ifu_rdata_q;
  logic [DATA_WIDTH-1:0] lsu_rdata_q;
  logic                  ifu_resp_valid_q;
  logic                  lsu_resp_valid_q;
  logic                  grant_ifu;
  logic                  grant_lsu;

  // Combinational grant in IDLE only; at most one requester sees ready.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.lsu_req_valid && (!bus.ifu_req_valid || prio_lsu_q)) begin
        grant_lsu = 1'b1;
      end else if (bus.ifu_req_valid) begin
        grant_ifu = 1'b1;
      end
    end
  end

  // Transaction FSM: latch on handshake, strobe, count latency, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      prio_lsu_q       <= 1'b1;
      owner_lsu_q      <= 1'b0;
      wen_q            <= 1'b0;
      strobe_q         <= 1'b0;
      cnt_q            <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_lsu || grant_ifu) begin
            owner_lsu_q <= grant_lsu;
            addr_q      <= grant_lsu ? bus.lsu_addr : bus.ifu_raddr;
            wen_q       <= grant_lsu && bus.lsu_wen;
            wdata_q     <= grant_lsu ? bus.lsu_wdata : '0;
            wmask_q     <= (grant_lsu && bus.lsu_wen) ? bus.lsu_wmask : 8'h00;
            prio_lsu_q  <= grant_ifu;
            cnt_q       <= LAT_INIT;
            strobe_q    <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (strobe_q) begin
            if (owner_lsu_q) begin
              lsu_rdata_q <= wen_q ? '0 : bus.mem_rdata;
            end else begin
              ifu_rdata_q <= bus.mem_rdata;
            end
          end
          if (cnt_q == 4'd0) begin
            state_q          <= RESP;
            lsu_resp_valid_q <= owner_lsu_q;
            ifu_resp_valid_q <= !owner_lsu_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if ((owner_lsu_q && bus.lsu_resp_ready) || (!owner_lsu_q && bus.ifu_resp_ready)) begin
            lsu_resp_valid_q <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so a reset in the strobe cycle suppresses them.
  assign bus.mem_ren        = strobe_q && !wen_q && !rst;
  assign bus.mem_wen        = strobe_q && wen_q && !rst;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign dbg_state_o        = state_q;

endmodule

// File: doc/ysyx_23060201_mem_arb.md
Name: ysyx_23060201_mem_arb

Overview:
- Two-requester arbiter and sequencer for the single physical-memory port (pmem read/write DPI path).
- Requesters: IFU (read-only instruction fetch) and LSU (load/store).
- Accepts one transaction at a time via valid/ready handshakes and drives exactly one memory strobe per transaction. Waits a programmable latency, then returns a response to the owning requester.
- Sits between IFU/LSU and the MEM block.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MEM_LAT, 1, cycles from strobe to response; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ifu_req_valid  input  1  IFU read request
- ifu_req_ready  output  1  IFU request accepted this cycle
- ifu_raddr  input  ADDR_WIDTH  IFU read address
- ifu_resp_valid  output  1  IFU read data valid
- ifu_resp_ready  input  1  IFU consumes response
- ifu_rdata  output  DATA_WIDTH  IFU read data
- lsu_req_valid  input  1  LSU request
- lsu_req_ready  output  1  LSU request accepted this cycle
- lsu_wen  input  1  1=write, 0=read
- lsu_addr  input  ADDR_WIDTH  LSU address
- lsu_wdata  input  DATA_WIDTH  LSU write data
- lsu_wmask  input  8  LSU byte write mask
- lsu_resp_valid  output  1  LSU response valid (read data or write ack)
- lsu_resp_ready  input  1  LSU consumes response
- lsu_rdata  output  DATA_WIDTH  LSU read data; 0 for writes
- mem_ren  output  1  memory read strobe
- mem_wen  output  1  memory write strobe
- mem_addr  output  ADDR_WIDTH  memory address (shared read/write)
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_wmask  output  8  memory write mask
- mem_rdata  input  DATA_WIDTH  memory read data, valid combinationally while mem_ren=1

Behaviour:

States:
- IDLE: no transaction in flight.
- ACCESS: latency counter runs.
- RESP: response is held for the owner.

Reset:
- state=IDLE; all *_ready, *_resp_valid, mem_ren, mem_wen = 0.
- mem_addr, mem_wdata, mem_wmask, *_rdata = 0.
- Round-robin pointer = LSU-first.

IDLE and arbitration:
- Only IDLE can assert a req_ready; it is combinational, to at most one requester.
- Exactly one valid: that requester gets ready=1.
- Both valid: the pointer selects the winner. After each grant the pointer flips to the other requester, so back-to-back contention alternates strictly.
- A handshake is valid&ready on a rising edge. On that edge the block latches addr, wen (IFU forced 0), wdata, wmask (forced 0 for reads) and owner, loads counter=MEM_LAT-1, and moves to ACCESS.
- A requester must hold valid and its payload stable until ready. The arbiter never withdraws ready within a cycle.

ACCESS:
- The first ACCESS cycle asserts mem_ren (read) or mem_wen (write) for exactly one cycle, with latched addr/wdata/wmask on the mem_* buses.
- On a read, mem_rdata is captured into the response register at the end of that cycle. On a write, the response register is cleared to 0.
- A write with wmask=0 is still strobed and still acknowledged.
- The counter decrements each cycle. At counter==0 the state goes to RESP on the next edge.
- Handshake in cycle T gives strobe in T+1 and resp_valid first in T+1+MEM_LAT.

RESP:
- The owner's resp_valid=1 and its rdata = captured value; the other resp_valid stays 0.
- Hold until resp_ready=1, then go to IDLE on that edge.
- A new request can be accepted the cycle after return to IDLE; there is no bypass.

Memory bus:
- mem_addr, mem_wdata and mem_wmask keep the last latched values outside strobe cycles.
- mem_ren and mem_wen are never both 1, and are 0 in every cycle with rst=1.

Reset mid-operation:
- rst in any state aborts the transaction: IDLE next edge, response lost, pointer reset.
- A strobe is suppressed if rst is high in that cycle.

Addresses and data pass through unmodified; no alignment checks.

Test Plan:
1. IFU read only, MEM_LAT=1: ifu_raddr=0x80000000, mem_rdata=0x00100073 → mem_ren 1 cycle at T+1, ifu_resp_valid at T+2 with ifu_rdata=0x00100073, lsu_resp_valid=0.
2. LSU write, MEM_LAT=3: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F → single mem_wen cycle with those values, lsu_resp_valid at T+4, lsu_rdata=0.
3. Both valid continuously for 4 transactions from reset → grants in order LSU, IFU, LSU, IFU; never two readys in one cycle.
4. Response backpressure: hold lsu_resp_ready=0 for 5 cycles → lsu_resp_valid and data stable, ifu_req_ready=0 throughout, IDLE one cycle after ready.
5. Assert rst during ACCESS with MEM_LAT=4 → no resp_valid afterward, all outputs 0 next cycle, next contested grant goes to LSU.
6. LSU write with wmask=0x00 → mem_wen pulses once with mem_wmask=0, ack returned normally.
